udp_txbuf_reader: RTL and testbench
===================================

# udp_txbuf_reader

Core-side engine for the UDP transmit-buffer interface. The application fills a word-addressed TX buffer while it holds `udp_txbuf_grant`, then pulses `udp_txbuf_rel`. This block reads the buffer, decodes the three header words and streams the payload byte-serially to the UDP/IP packet builder. It returns the grant when the whole packet has been handed off. It sits inside `ros2_ether` between the application TX buffer port and the UDP frame generator.

## Interface
- `AWIDTH`, default 6: TX buffer word-address width (equals `UDP_TXBUF_AWIDTH`).
- `MAX_LEN`, default 244: largest payload length accepted, in bytes. Must be ≤ 4·(2^AWIDTH−3).

- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: block enable.
- `udp_txbuf_grant` out 1: high while the application owns the buffer.
- `udp_txbuf_rel` in 1: one-cycle pulse from the application meaning "buffer filled, take it".
- `udp_txbuf_addr` out AWIDTH: buffer word address.
- `udp_txbuf_ce` out 1: read strobe for the buffer.
- `udp_txbuf_rdata` in 32: buffer read data, valid one cycle after the matching addr/ce cycle.
- `hdr_valid` out 1 and `hdr_ready` in 1: header handshake.
- `hdr_dst_ip` out 32: destination IP address.
- `hdr_src_port` out 16: UDP source port.
- `hdr_dst_port` out 16: UDP destination port.
- `hdr_len` out 16: payload length in bytes.
- `pl_data` out 8 and `pl_valid` out 1: payload byte stream.
- `pl_last` out 1: marks the final payload byte.
- `pl_ready` in 1: payload handshake from the packet builder.
- `err_len` out 1: one-cycle pulse when a packet is dropped because its length exceeds MAX_LEN.

## Operation
- Buffer layout, one 32-bit word per address:
  - Word 0: destination IP. Byte 0 (bits 7:0) is the first octet, so 32'h0a01a8c0 means 192.168.1.10.
  - Word 1: bits 31:16 are the source port, bits 15:0 the destination port.
  - Word 2: bits 15:0 are the payload length; bits 31:16 are ignored.
  - Word 3 onward: payload, least-significant byte first within each word.
- States: IDLE, RD_HDR, HDR, FETCH, WAIT, STREAM, DROP, DONE.
- IDLE
  - `udp_txbuf_grant` is registered from `enable`.
  - A `udp_txbuf_rel` sampled while `grant`=1 moves the block to RD_HDR and drops `grant`.
  - `udp_txbuf_rel` is ignored in every other state, and whenever `grant`=0.
- RD_HDR
  - Issues addresses 0, 1, 2 on consecutive cycles with `ce`=1.
  - Captures each word into the header registers one cycle after its address.
- Length check, after word 2 is captured:
  - If `hdr_len` > MAX_LEN, go to DROP: `err_len` pulses, no header or payload is emitted, then DONE.
  - Otherwise go to HDR.
- HDR
  - `hdr_valid`=1, with fields stable until `hdr_valid && hdr_ready`.
  - After the handshake: if `hdr_len`=0, go to DONE; otherwise go to FETCH with word pointer 3.
- FETCH → WAIT → STREAM
  - FETCH drives `addr`=pointer with `ce`=1 for one cycle.
  - WAIT loads `rdata` into the word register.
  - STREAM presents bytes 0..3 in order. Each byte is held until `pl_ready`.
  - A byte counter of width 16 counts bytes sent. Streaming stops at byte `hdr_len`−1, and unused trailing bytes of the last word are never emitted.
  - `pl_last`=1 only on byte `hdr_len`−1.
  - After byte 3 of a word is accepted and bytes remain, the pointer increments and the block returns to FETCH.
- DONE: lasts one cycle, then IDLE, where `grant` rises again.
- `enable` deasserted mid-packet: the current packet completes normally. The block then stays in IDLE with `grant`=0.
- `ce`=0 and `addr` holds its last value outside FETCH and RD_HDR.

## Timing
- Reset values: `grant`=0, `addr`=0, `ce`=0, `hdr_valid`=0, all `hdr_*` fields=0, `pl_valid`=0, `pl_last`=0, `pl_data`=0, `err_len`=0. State is IDLE.
- First cycle after reset release: `grant`=`enable`.
- All outputs are registered.
- Let cycle R be the cycle in which `rel` is sampled.
  - R+1: `grant`=0, `addr`=0, `ce`=1.
  - R+2: `addr`=1.
  - R+3: `addr`=2.
  - R+5: `hdr_valid`=1, or `err_len` pulses for an oversize length.
- Let cycle H be the header handshake cycle. FETCH is at H+1 and the first `pl_valid` is at H+3.
- Between words there is a fixed 2-cycle bubble: `pl_valid`=0 during FETCH and WAIT.
- Let cycle L be the cycle the last byte is accepted, or the cycle of the zero-length header handshake, or the `err_len` cycle. DONE is at L+1 and `grant`=1 at L+2.
- Reset asserted mid-operation: all outputs go to reset values immediately. The partial packet is discarded.

## Test plan
- Buffer {0x0a01a8c0, 0x045704d2, 7, 0x20504455, 0x00000074, …}, `rel` at R, `hdr_ready`=`pl_ready`=1:
  - Header is 192.168.1.10, ports 1111→1234, len 7, with `hdr_valid` at R+5.
  - Bytes are 55 44 50 20 74 00 00. `pl_last` is on the 7th byte only.
  - `grant` is back high 2 cycles after the last byte.
- len=4: exactly one word is fetched and there is no bubble before `pl_last`. len=5: a second fetch occurs and exactly one byte (LSB) is emitted from it.
- len=0: header is accepted, no `pl_valid`, and `grant` returns at H+2. len=245 with MAX_LEN=244: `err_len` pulses at R+5, no `hdr_valid`, and `grant` returns at R+7.
- Backpressure: random `hdr_ready` and `pl_ready` stalls. The byte sequence is unchanged, `pl_data` is stable while `pl_valid && !pl_ready`, and `hdr_*` is stable while waiting.
- `rel` pulses during streaming and while `enable`=0: both are ignored. `enable` dropped mid-packet: the packet completes, then `grant` stays 0 until `enable`=1.
- `rst_n` asserted mid-STREAM: all outputs take reset values in the same cycle. After release, `grant` rises and a fresh `rel` produces a correct packet.

Source files
------------

// File: rtl/udp_txbuf_reader.sv
// udp_txbuf_reader
// Reads a filled UDP TX buffer, decodes the three header words and streams
// the payload byte-serially to the UDP/IP packet builder.  The buffer grant
// goes back to the application once the whole packet has been handed off.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : block enable; when low the grant is not re-issued
//   udp_txbuf_grant     : application owns the buffer while high
//   udp_txbuf_rel       : one-cycle "buffer filled" pulse from the application
//   udp_txbuf_addr/ce   : buffer word address and read strobe
//   udp_txbuf_rdata     : buffer read data, one cycle after addr/ce
//   hdr_valid/ready     : header handshake
//   hdr_dst_ip          : destination IP (byte 0 is the first octet)
//   hdr_src_port        : UDP source port
//   hdr_dst_port        : UDP destination port
//   hdr_len             : payload length in bytes
//   pl_data/valid/last  : payload byte stream, last marks the final byte
//   pl_ready            : payload handshake
//   err_len             : one-cycle pulse when an oversize packet is dropped
module udp_txbuf_reader #(
    parameter int unsigned AWIDTH  = 6,
    parameter int unsigned MAX_LEN = 244
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              udp_txbuf_grant,
    input  logic              udp_txbuf_rel,
    output logic [AWIDTH-1:0] udp_txbuf_addr,
    output logic              udp_txbuf_ce,
    input  logic [31:0]       udp_txbuf_rdata,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [31:0]       hdr_dst_ip,
    output logic [15:0]       hdr_src_port,
    output logic [15:0]       hdr_dst_port,
    output logic [15:0]       hdr_len,
    output logic [7:0]        pl_data,
    output logic              pl_valid,
    output logic              pl_last,
    input  logic              pl_ready,
    output logic              err_len
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam logic [LEN_W-1:0]  MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [AWIDTH-1:0] PL_BASE   = AWIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HDR,
        S_HDR,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_DROP,
        S_DONE
    } state_t;

    // Decoded header as held for the packet builder
    typedef struct packed {
        logic [31:0]      dst_ip;
        logic [15:0]      src_port;
        logic [15:0]      dst_port;
        logic [LEN_W-1:0] len;
    } hdr_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic                ce_q, ce_d;
    hdr_t                hdr_q, hdr_d;
    logic                hdr_valid_q, hdr_valid_d;
    logic [7:0]          pl_data_q, pl_data_d;
    logic                pl_valid_q, pl_valid_d;
    logic                pl_last_q, pl_last_d;
    logic                err_len_q, err_len_d;
    logic [1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          sel_nxt;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_m1;

    // Index of the final payload byte; only used once len is known non-zero
    assign len_m1 = hdr_q.len - LEN_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= 1'b0;
            addr_q      <= '0;
            ce_q        <= 1'b0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            err_len_q   <= 1'b0;
            idx_q       <= '0;
            word_q      <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
        end else begin
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            ce_q        <= ce_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            pl_last_q   <= pl_last_d;
            err_len_q   <= err_len_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        ce_d        = 1'b0;
        hdr_d       = hdr_q;
        hdr_valid_d = hdr_valid_q;
        pl_data_d   = pl_data_q;
        pl_valid_d  = pl_valid_q;
        pl_last_d   = pl_last_q;
        err_len_d   = 1'b0;
        idx_d       = idx_q;
        word_d      = word_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        sel_nxt     = sel_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                grant_d = enable;
                if (grant_q && udp_txbuf_rel) begin
                    state_d = S_RD_HDR;
                    grant_d = 1'b0;
                    addr_d  = '0;
                    ce_d    = 1'b1;
                    idx_d   = '0;
                end
            end

            // idx_q counts cycles since address 0 was issued; word n lands
            // on idx_q == n+1 because of the one-cycle read latency.
            S_RD_HDR: begin
                idx_d = idx_q + 2'd1;
                if (idx_q < 2'd2) begin
                    addr_d = addr_q + AWIDTH'(1);
                    ce_d   = 1'b1;
                end
                case (idx_q)
                    2'd1: hdr_d.dst_ip = udp_txbuf_rdata;
                    2'd2: begin
                        hdr_d.src_port = udp_txbuf_rdata[31:16];
                        hdr_d.dst_port = udp_txbuf_rdata[15:0];
                    end
                    2'd3: begin
                        hdr_d.len = udp_txbuf_rdata[15:0];
                        if (udp_txbuf_rdata[15:0] > MAX_LEN_W) begin
                            state_d   = S_DROP;
                            err_len_d = 1'b1;
                        end else begin
                            state_d     = S_HDR;
                            hdr_valid_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            S_HDR: begin
                if (hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    if (hdr_q.len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = PL_BASE;
                        ce_d    = 1'b1;
                        cnt_d   = '0;
                        sel_d   = '0;
                    end
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            // Word arrives: present its first byte straight from rdata
            S_WAIT: begin
                word_d     = udp_txbuf_rdata;
                pl_data_d  = udp_txbuf_rdata[7:0];
                pl_valid_d = 1'b1;
                pl_last_d  = (cnt_q == len_m1);
                sel_d      = '0;
                state_d    = S_STREAM;
            end

            S_STREAM: begin
                if (pl_ready) begin
                    if (pl_last_q) begin
                        pl_valid_d = 1'b0;
                        pl_last_d  = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if (sel_q == 2'd3) begin
                            // Word exhausted with bytes remaining: refetch
                            pl_valid_d = 1'b0;
                            pl_last_d  = 1'b0;
                            addr_d     = addr_q + AWIDTH'(1);
                            ce_d       = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            sel_d     = sel_nxt;
                            pl_data_d = 8'(word_q >> {sel_nxt, 3'b000});
                            pl_last_d = ((cnt_q + LEN_W'(1)) == len_m1);
                        end
                    end
                end
            end

            S_DROP: begin
                state_d = S_DONE;
            end

            S_DONE: begin
                grant_d = enable;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign udp_txbuf_grant = grant_q;
    assign udp_txbuf_addr  = addr_q;
    assign udp_txbuf_ce    = ce_q;
    assign hdr_valid       = hdr_valid_q;
    assign hdr_dst_ip      = hdr_q.dst_ip;
    assign hdr_src_port    = hdr_q.src_port;
    assign hdr_dst_port    = hdr_q.dst_port;
    assign hdr_len         = hdr_q.len;
    assign pl_data         = pl_data_q;
    assign pl_valid        = pl_valid_q;
    assign pl_last         = pl_last_q;
    assign err_len         = err_len_q;

endmodule

// File: tb/tb_udp_txbuf_reader.sv
// Testbench for udp_txbuf_reader: buffer memory model, randomized contents
// and handshake stalls, expected header/bytes derived from the buffer image.
module tb_udp_txbuf_reader;

    localparam int unsigned AWIDTH  = 6;
    localparam int          MAX_LEN = 244;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              grant;
    logic              rel;
    logic [AWIDTH-1:0] addr;
    logic              ce;
    logic [31:0]       rdata;
    logic              hdr_valid;
    logic              hdr_ready;
    logic [31:0]       hdr_dst_ip;
    logic [15:0]       hdr_src_port;
    logic [15:0]       hdr_dst_port;
    logic [15:0]       hdr_len;
    logic [7:0]        pl_data;
    logic              pl_valid;
    logic              pl_last;
    logic              pl_ready;
    logic              err_len;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    udp_txbuf_reader #(.AWIDTH(AWIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .udp_txbuf_grant (grant),
        .udp_txbuf_rel   (rel),
        .udp_txbuf_addr  (addr),
        .udp_txbuf_ce    (ce),
        .udp_txbuf_rdata (rdata),
        .hdr_valid       (hdr_valid),
        .hdr_ready       (hdr_ready),
        .hdr_dst_ip      (hdr_dst_ip),
        .hdr_src_port    (hdr_src_port),
        .hdr_dst_port    (hdr_dst_port),
        .hdr_len         (hdr_len),
        .pl_data         (pl_data),
        .pl_valid        (pl_valid),
        .pl_last         (pl_last),
        .pl_ready        (pl_ready),
        .err_len         (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read TX buffer
    always @(posedge clk) begin
        if (ce) rdata <= mem[addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_grant", grant, 0);
        check("rst_addr", addr, 0);
        check("rst_ce", ce, 0);
        check("rst_hv", hdr_valid, 0);
        check("rst_hdr", {hdr_dst_ip, hdr_src_port, hdr_dst_port}, 0);
        check("rst_len", hdr_len, 0);
        check("rst_pl", {pl_valid, pl_last, pl_data}, 0);
        check("rst_err", err_len, 0);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[2] = {16'($urandom), 16'(len)};
    endtask

    // One packet from rel to grant return.  hp/pp are ready probabilities in
    // percent; abort_at > 0 asserts reset after that many accepted bytes.
    task automatic run_packet(input int hp, input int pp, input bit inj_rel,
                              input bit drop_en, input int abort_at);
        int len, words, fetches, bubbles, acc, guard;
        bit over, hs, hdr_ok, data_ok, prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp_q[$];
        logic [31:0] e_ip;
        logic [15:0] e_sp, e_dp;

        guard = 0;
        while (!grant && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("grant_wait", grant, 1);

        len  = int'(mem[2][15:0]);
        over = (len > MAX_LEN);
        e_ip = mem[0];
        e_sp = mem[1][31:16];
        e_dp = mem[1][15:0];
        if (!over)
            for (int i = 0; i < len; i++) exp_q.push_back(8'(mem[3 + i / 4] >> (8 * (i % 4))));
        words = (len + 3) / 4;

        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        check("r1_grant", grant, 0);
        check("r1_addr", addr, 0);
        check("r1_ce", ce, 1);
        @(negedge clk);
        check("r2_addr", addr, 1);
        @(negedge clk);
        check("r3_addr", addr, 2);
        @(negedge clk);
        check("r4_ce", ce, 0);
        check("r4_hv", hdr_valid, 0);
        @(negedge clk);

        if (over) begin
            check("r5_err", err_len, 1);
            check("r5_hv", hdr_valid, 0);
            @(negedge clk);
            check("r6_err", err_len, 0);
            check("r6_grant", grant, 0);
            check("r6_hv_pv", {hdr_valid, pl_valid}, 0);
            @(negedge clk);
            check("r7_grant", grant, 1);
            return;
        end

        check("r5_hv", hdr_valid, 1);
        check("r5_err", err_len, 0);
        hdr_ok = 1'b1;
        hs     = 1'b0;
        guard  = 0;
        while (!hs && guard < 1000) begin
            if (!hdr_valid || hdr_dst_ip !== e_ip || hdr_src_port !== e_sp ||
                hdr_dst_port !== e_dp || hdr_len !== 16'(len) || pl_valid)
                hdr_ok = 1'b0;
            hdr_ready = ($urandom_range(99) < 32'(hp));
            hs        = hdr_ready;
            if (hs) begin
                check("hdr_ip", hdr_dst_ip, e_ip);
                check("hdr_ports", {hdr_src_port, hdr_dst_port}, {e_sp, e_dp});
                check("hdr_len", hdr_len, 16'(len));
                if (drop_en) enable = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        hdr_ready = 1'b0;
        check("hdr_handshake", hs, 1);
        check("hdr_stable", hdr_ok, 1);
        check("h1_hv", hdr_valid, 0);

        if (len == 0) begin
            check("z_h1_pv", pl_valid, 0);
            check("z_h1_grant", grant, 0);
            @(negedge clk);
            check("z_h2_grant", grant, 1);
            return;
        end

        check("h1_fetch", {ce, addr}, {1'b1, AWIDTH'(3)});
        check("h1_pv", pl_valid, 0);
        @(negedge clk);
        check("h2_pv", pl_valid, 0);
        @(negedge clk);
        check("h3_pv", pl_valid, 1);

        fetches    = 1;
        bubbles    = 0;
        acc        = 0;
        guard      = 0;
        data_ok    = 1'b1;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (acc < len && guard < 5000) begin
            if (abort_at > 0 && acc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals();
                pl_ready = 1'b0;
                rel      = 1'b0;
                return;
            end
            if (ce && addr >= AWIDTH'(3)) fetches++;
            if (!pl_valid) bubbles++;
            else if (prev_stall && pl_data !== prev_data) data_ok = 1'b0;
            pl_ready = ($urandom_range(99) < 32'(pp));
            rel      = inj_rel && ($urandom_range(3) == 0);
            if (pl_valid && pl_ready) begin
                check("byte", pl_data, exp_q[acc]);
                check("last", pl_last, (acc == len - 1));
                acc++;
            end
            prev_stall = pl_valid && !pl_ready;
            prev_data  = pl_data;
            @(negedge clk);
            guard++;
        end
        pl_ready = 1'b0;
        rel      = 1'b0;
        check("byte_count", acc, len);
        check("pl_stable", data_ok, 1);
        check("fetches", fetches, words);
        check("bubbles", bubbles, 2 * (words - 1));
        check("l1_grant", grant, 0);
        check("l1_pv", pl_valid, 0);
        @(negedge clk);
        check("l2_grant", grant, drop_en ? 0 : 1);
    endtask

    initial begin
        bit ce_seen;

        rst_n     = 1'b0;
        enable    = 1'b1;
        rel       = 1'b0;
        hdr_ready = 1'b0;
        pl_ready  = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", grant, 1);

        // Reference packet
        fill_random(7);
        mem[0] = 32'h0a01a8c0;
        mem[1] = 32'h045704d2;
        mem[2] = 32'd7;
        mem[3] = 32'h20504455;
        mem[4] = 32'h00000074;
        run_packet(100, 100, 0, 0, 0);

        // Length boundaries
        fill_random(4);   run_packet(100, 100, 0, 0, 0);
        fill_random(5);   run_packet(100, 100, 0, 0, 0);
        fill_random(1);   run_packet(100, 100, 0, 0, 0);
        fill_random(0);   run_packet(100, 100, 0, 0, 0);
        fill_random(245); run_packet(100, 100, 0, 0, 0);
        fill_random(244); run_packet(100, 100, 0, 0, 0);
        fill_random(65535); run_packet(100, 100, 0, 0, 0);

        // Randomized lengths, stalls and stray rel pulses
        for (int p = 0; p < 20; p++) begin
            fill_random(int'($urandom_range(250)));
            run_packet(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                       1'($urandom_range(1)), 0, 0);
        end

        // enable dropped mid-packet, then rel while grant is low
        fill_random(9);
        run_packet(100, 60, 1, 1, 0);
        repeat (3) @(negedge clk);
        check("en0_grant", grant, 0);
        rel = 1'b1;
        ce_seen = 1'b0;
        @(negedge clk);
        rel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ce || grant) ce_seen = 1'b1;
            @(negedge clk);
        end
        check("en0_rel_ignored", ce_seen, 0);
        enable = 1'b1;
        @(negedge clk);
        check("en1_grant", grant, 1);
        fill_random(6);
        run_packet(100, 100, 0, 0, 0);

        // Reset in the middle of streaming, then a fresh packet
        fill_random(12);
        run_packet(100, 100, 0, 0, 2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_grant", grant, 1);
        fill_random(11);
        run_packet(70, 70, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
